// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter.
// The main register (M) drives the out_* ports. The skid register (S) catches the
// word accepted in the cycle the stage fills, so in_ready can come straight from a flop.
module pipe_stage_skid #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NFIELD = 3,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELD*WIDTH-1:0]  in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELD*WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned DW = NFIELD * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Holding state: EMPTY (nothing), ONE (M only), TWO (M and S).
  // S is only ever valid when M is valid, so three states cover every case.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  state_e            state_q, state_d;

  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic [CNT_W-1:0]  stall_q,     stall_d;

  logic [DW-1:0]     m_data_q, m_data_d;
  logic [TAG_W-1:0]  m_tag_q,  m_tag_d;
  logic [DW-1:0]     s_data_q, s_data_d;
  logic [TAG_W-1:0]  s_tag_q,  s_tag_d;

  logic              accept_c;
  logic              drain_c;
  logic              m_load_in_c;
  logic              m_load_skid_c;
  logic              s_load_c;

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, register-load enables and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    m_load_in_c   = 1'b0;
    m_load_skid_c = 1'b0;
    s_load_c      = 1'b0;
    accept_c      = in_valid & in_ready_q;
    drain_c       = out_valid_q & out_ready;

    if (flush) begin
      // Squash everything held; any word offered this cycle is dropped.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            m_load_in_c = 1'b1;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (drain_c) begin
            // Drain and refill in the same cycle keeps one word per cycle.
            if (accept_c) begin
              m_load_in_c = 1'b1;
              state_d     = ST_ONE;
            end else begin
              state_d     = ST_EMPTY;
            end
          end else if (accept_c) begin
            // Downstream stalled: the word already in flight lands in S.
            s_load_c = 1'b1;
            state_d  = ST_TWO;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can change anything.
          if (drain_c) begin
            m_load_skid_c = 1'b1;
            state_d       = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_ONE:  occupancy_d = 2'(1);
      ST_TWO:  occupancy_d = 2'(2);
      default: occupancy_d = 2'(0);
    endcase
  end

  // Handshake and occupancy outputs, each straight from its own flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'(0);
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  // Next values of the M and S data/tag registers.
  always_comb begin
    m_data_d = m_data_q;
    m_tag_d  = m_tag_q;
    s_data_d = s_data_q;
    s_tag_d  = s_tag_q;
    if (m_load_in_c) begin
      m_data_d = in_data;
      m_tag_d  = in_tag;
    end else if (m_load_skid_c) begin
      m_data_d = s_data_q;
      m_tag_d  = s_tag_q;
    end
    if (s_load_c) begin
      s_data_d = in_data;
      s_tag_d  = in_tag;
    end
  end

  // Data and tag registers; left untouched by flush since valid gates them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data_q <= DW'(0);
      m_tag_q  <= TAG_W'(0);
      s_data_q <= DW'(0);
      s_tag_q  <= TAG_W'(0);
    end else begin
      m_data_q <= m_data_d;
      m_tag_q  <= m_tag_d;
      s_data_q <= s_data_d;
      s_tag_q  <= s_tag_d;
    end
  end

  // Stall counter next value: counts output-stalled cycles, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= CNT_W'(0);
    end else begin
      stall_q <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_data_q;
  assign out_tag   = m_tag_q;
  assign occupancy = occupancy_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, checked
// against a queue-based model of the stage's FIFO behaviour.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_data = 24'h0;
  logic [3:0]  in_tag = 4'h0;

  logic        in_ready, out_valid;
  logic [23:0] out_data;
  logic [3:0]  out_tag;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        in_ready3, out_valid3;
  logic [23:0] out_data3;
  logic [3:0]  out_tag3;
  logic [1:0]  occupancy3;
  logic [2:0]  stall_cnt3;

  pipe_stage_skid u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_tag(out_tag3),
    .occupancy(occupancy3), .stall_cnt(stall_cnt3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  t;
  } word_t;

  word_t       q[$];
  int unsigned c16 = 0;
  int unsigned c3  = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready",   32'(in_ready),   32'(q.size() < 2));
    chk("out_valid",  32'(out_valid),  32'(q.size() > 0));
    chk("occupancy",  32'(occupancy),  32'(q.size()));
    chk("stall_cnt",  32'(stall_cnt),  c16);
    chk("in_ready3",  32'(in_ready3),  32'(q.size() < 2));
    chk("occupancy3", 32'(occupancy3), 32'(q.size()));
    chk("stall_cnt3", 32'(stall_cnt3), c3);
    if (q.size() > 0) begin
      chk("out_data",  32'(out_data),  32'(q[0].d));
      chk("out_tag",   32'(out_tag),   32'(q[0].t));
      chk("out_data3", 32'(out_data3), 32'(q[0].d));
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(out_valid),  32'(0));
    chk("rst_in_ready",  32'(in_ready),   32'(1));
    chk("rst_occupancy", 32'(occupancy),  32'(0));
    chk("rst_stall_cnt", 32'(stall_cnt),  32'(0));
    chk("rst_out_data",  32'(out_data),   32'(0));
    chk("rst_out_tag",   32'(out_tag),    32'(0));
    chk("rst_stall3",    32'(stall_cnt3), 32'(0));
    chk("rst_valid3",    32'(out_valid3), 32'(0));
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
  task automatic step(input logic iv, input logic [23:0] d, input logic [3:0] t,
                      input logic ordy, input logic fl);
    bit acc, drn, stl;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    #2;
    check_model();
    acc = iv && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    stl = (q.size() > 0) && !ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) q.delete(0);
      if (acc) q.push_back('{d: d, t: t});
    end
    if (stl) begin
      if (c16 < 65535) c16++;
      if (c3 < 7) c3++;
    end
  endtask

  initial begin
    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals();

    // Streaming with out_ready high.
    step(1'b1, 24'h030201, 4'd5, 1'b1, 1'b0);
    step(1'b1, 24'h060504, 4'd6, 1'b1, 1'b0);
    step(1'b0, 24'h0,      4'd0, 1'b1, 1'b0);
    step(1'b0, 24'h0,      4'd0, 1'b1, 1'b0);

    // Backpressure fills the skid, then drains in order.
    step(1'b1, 24'h0A0A0A, 4'hA, 1'b0, 1'b0);
    step(1'b1, 24'h0B0B0B, 4'hB, 1'b0, 1'b0);
    repeat (3) step(1'b0, 24'h0, 4'd0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 24'h0, 4'd0, 1'b1, 1'b0);

    // Simultaneous drain and accept with S empty.
    step(1'b1, 24'h0A0A0A, 4'h1, 1'b1, 1'b0);
    step(1'b1, 24'h0C0C0C, 4'hC, 1'b1, 1'b0);
    step(1'b0, 24'h0,      4'd0, 1'b0, 1'b0);
    step(1'b0, 24'h0,      4'd0, 1'b1, 1'b0);

    // Flush while full with a word offered; then flush at occupancy 1 with in_ready high.
    step(1'b1, 24'h111111, 4'h1, 1'b0, 1'b0);
    step(1'b1, 24'h222222, 4'h2, 1'b0, 1'b0);
    step(1'b1, 24'h333333, 4'h3, 1'b0, 1'b1);
    step(1'b1, 24'h444444, 4'h4, 1'b0, 1'b0);
    step(1'b1, 24'h555555, 4'h5, 1'b0, 1'b1);
    step(1'b0, 24'h0,      4'd0, 1'b1, 1'b0);
    step(1'b0, 24'h0,      4'd0, 1'b1, 1'b0);

    // Long stall saturates the narrow counter.
    step(1'b1, 24'h777777, 4'h7, 1'b0, 1'b0);
    repeat (10) step(1'b0, 24'h0, 4'd0, 1'b0, 1'b0);
    #3;
    chk("sat3", 32'(stall_cnt3), 32'(7));

    // Asynchronous reset between edges while stalled.
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    q.delete();
    c16 = 0;
    c3  = 0;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_vals();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom % 2), 24'($urandom), 4'($urandom),
           1'(($urandom % 10) < 7), 1'(($urandom % 25) == 0));
    end
    // Random traffic with heavy backpressure.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom % 2), 24'($urandom), 4'($urandom),
           1'(($urandom % 4) == 0), 1'(($urandom % 40) == 0));
    end
    step(1'b0, 24'h0, 4'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
